// File: rtl/ascon_wb_regs.sv
// Wishbone classic slave for the ASCON accelerator: buffer pass-through plus CTRL/LEN/STATUS registers.
// Optional interrupt enable (CTRL bit8) and irq output are built only when ASCON_WB_IRQ_EN is defined.
module ascon_wb_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] datain_wb,
    input  logic [31:0] mem_dataout,
    output logic        busy,
    output logic [6:0]  datalen,
    output logic        mode,
    input  logic        ascon_done,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q;
    logic [31:0] dat_o_q, dat_o_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mode_q, mode_d;
    logic [6:0]  len_q, len_d;
    logic        rd_blk_q, rd_blk_d;
    logic        irq_en_q;

    logic        hit, start, is_buf, buf_wr, ctrl_wr;
    logic [7:0]  offset;
    logic [31:0] reg_rdata;

    assign offset  = wbs_adr_i[7:0];
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign start   = (state_q == IDLE) & hit;
    assign is_buf  = ~offset[7];
    assign buf_wr  = start & wbs_we_i & is_buf & ~busy_q;
    assign ctrl_wr = start & wbs_we_i & (offset == 8'h80);

    // Buffer strobe and address are presented combinationally in the detection cycle
    assign wb_we     = ~buf_wr;
    assign wb_addr   = start ? wbs_adr_i[6:2] : addr_q;
    assign datain_wb = buf_wr ? wbs_dat_i : 32'h0;

    assign wbs_ack_o = (state_q == ACK);
    assign wbs_dat_o = dat_o_q;
    assign busy      = busy_q;
    assign datalen   = len_q;
    assign mode      = mode_q;
    assign irq       = done_q & irq_en_q;

    wire unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        reg_rdata = 32'h0;
        case (offset)
            8'h80:   reg_rdata = {23'h0, irq_en_q, 6'h0, mode_q, 1'b0};
            8'h84:   reg_rdata = {25'h0, len_q};
            8'h88:   reg_rdata = {30'h0, done_q, busy_q};
            default: reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dat_o_d  = dat_o_q;
        busy_d   = busy_q;
        done_d   = done_q;
        mode_d   = mode_q;
        len_d    = len_q;
        rd_blk_d = rd_blk_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (!wbs_we_i && is_buf) begin
                        state_d  = RD_WAIT;
                        rd_blk_d = busy_q;
                    end else begin
                        state_d = ACK;
                    end
                    if (!wbs_we_i && !is_buf) begin
                        dat_o_d = reg_rdata;
                    end
                end
            end
            RD_WAIT: begin
                dat_o_d = rd_blk_q ? 32'h0 : mem_dataout;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start && wbs_we_i && !busy_q) begin
            if (offset == 8'h80) begin
                mode_d = wbs_dat_i[1];
                if (wbs_dat_i[0] && (len_q != 7'd0)) begin
                    busy_d = 1'b1;
                end
            end
            if (offset == 8'h84) begin
                len_d = wbs_dat_i[6:0];
            end
        end
        if (start && wbs_we_i && (offset == 8'h88) && wbs_dat_i[1]) begin
            done_d = 1'b0;
        end
        // Completion has priority over a simultaneous DONE clear
        if (ascon_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            addr_q   <= 5'd0;
            dat_o_q  <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            len_q    <= 7'd0;
            rd_blk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= wb_addr;
            dat_o_q  <= dat_o_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            rd_blk_q <= rd_blk_d;
        end
    end

`ifdef ASCON_WB_IRQ_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            irq_en_q <= 1'b0;
        end else if (ctrl_wr && !busy_q) begin
            irq_en_q <= wbs_dat_i[8];
        end
    end
`else
    assign irq_en_q = 1'b0;
    wire unused_ctrl = &{1'b0, ctrl_wr};
`endif

endmodule

// File: tb/tb_ascon_wb_regs.sv
// Directed table-driven bench for ascon_wb_regs with a synchronous buffer model.
module tb_ascon_wb_regs;

`ifdef ASCON_WB_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] datain_wb;
    logic [31:0] mem_dataout = 32'h0;
    logic        busy;
    logic [6:0]  datalen;
    logic        mode;
    logic        ascon_done = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_wb_regs dut (
        .clk(clk), .nRST(nRST),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .wb_we(wb_we), .wb_addr(wb_addr), .datain_wb(datain_wb),
        .mem_dataout(mem_dataout),
        .busy(busy), .datalen(datalen), .mode(mode),
        .ascon_done(ascon_done), .irq(irq)
    );

    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (!wb_we) mem[wb_addr] <= datain_wb;
        mem_dataout <= mem[wb_addr];
    end

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          done;
        int          lat;
        logic [31:0] rd;
        int          we_low;
        logic [4:0]  waddr;
        bit          busy;
        logic [6:0]  len;
        bit          mode;
        bit          irq;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] dat, input bit done,
                          output int lat, output logic [31:0] rd, output int we_low,
                          output logic [4:0] waddr, output logic [31:0] wdata);
        lat = 0; rd = 32'h0; we_low = 0; waddr = 5'd0; wdata = 32'h0;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  ascon_done = done;
        #1;
        if (!wb_we) begin
            we_low++; waddr = wb_addr; wdata = datain_wb;
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            ascon_done = 1'b0;
            if (!wb_we) we_low++;
            if (wbs_ack_o) begin
                lat = c; rd = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (lat != 0) begin
            @(posedge clk); #1;
            chk($sformatf("ack_width adr=%h", adr), {31'h0, wbs_ack_o}, 32'h0);
        end
    endtask

    task automatic add(input bit we, input logic [31:0] adr, input logic [31:0] dat, input bit done,
                       input int lat, input logic [31:0] rd, input int we_low, input logic [4:0] waddr,
                       input bit b, input logic [6:0] len, input bit m, input bit i);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.done = done; v.lat = lat; v.rd = rd;
        v.we_low = we_low; v.waddr = waddr; v.busy = b; v.len = len; v.mode = m; v.irq = i;
        vecs.push_back(v);
    endtask

    initial begin
        int lat, we_low;
        logic [31:0] rd, wdata;
        logic [4:0] waddr;

        //   we adr            dat           dn lat rd            wl wa  busy len    mode irq
        add(1, 32'h3000_0000, 32'hA5A5_0001, 0, 1, 32'h0,         1, 0,  0, 7'h00, 0, 0);
        add(0, 32'h3000_0000, 32'h0,         0, 2, 32'hA5A5_0001, 0, 0,  0, 7'h00, 0, 0);
        add(1, 32'h3000_007C, 32'hDEAD_BEEF, 0, 1, 32'h0,         1, 31, 0, 7'h00, 0, 0);
        add(0, 32'h3000_007C, 32'h0,         0, 2, 32'hDEAD_BEEF, 0, 0,  0, 7'h00, 0, 0);
        add(1, 32'h3000_0084, 32'hFFFF_FFA5, 0, 1, 32'h0,         0, 0,  0, 7'h25, 0, 0);
        add(0, 32'h3000_0084, 32'h0,         0, 1, 32'h0000_0025, 0, 0,  0, 7'h25, 0, 0);
        add(1, 32'h3000_0080, 32'h0000_0003, 0, 1, 32'h0,         0, 0,  1, 7'h25, 1, 0);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0000_0001, 0, 0,  1, 7'h25, 1, 0);
        add(0, 32'h3000_0080, 32'h0,         0, 1, 32'h0000_0002, 0, 0,  1, 7'h25, 1, 0);
        add(1, 32'h3000_007C, 32'hFFFF_FFFF, 0, 1, 32'h0,         0, 0,  1, 7'h25, 1, 0);
        add(0, 32'h3000_007C, 32'h0,         0, 2, 32'h0,         0, 0,  1, 7'h25, 1, 0);
        add(1, 32'h3000_0084, 32'h0000_0010, 0, 1, 32'h0,         0, 0,  1, 7'h25, 1, 0);
        add(1, 32'h3000_0080, 32'h0,         0, 1, 32'h0,         0, 0,  1, 7'h25, 1, 0);
        add(1, 32'h3000_0080, 32'h0000_0101, 1, 1, 32'h0,         0, 0,  0, 7'h25, 1, 0);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0000_0002, 0, 0,  0, 7'h25, 1, 0);
        add(1, 32'h3000_0088, 32'h0000_0002, 0, 1, 32'h0,         0, 0,  0, 7'h25, 1, 0);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0,         0, 0,  0, 7'h25, 1, 0);
        add(0, 32'h3000_007C, 32'h0,         0, 2, 32'hDEAD_BEEF, 0, 0,  0, 7'h25, 1, 0);
        add(1, 32'h3000_0080, 32'h0000_0100, 0, 1, 32'h0,         0, 0,  0, 7'h25, 0, 0);
        add(0, 32'h3000_0080, 32'h0,         0, 1, IRQ ? 32'h100 : 32'h0, 0, 0, 0, 7'h25, 0, 0);
        add(1, 32'h3000_0080, 32'h0000_0101, 0, 1, 32'h0,         0, 0,  1, 7'h25, 0, 0);
        add(0, 32'h3000_0088, 32'h0,         1, 1, 32'h0000_0001, 0, 0,  0, 7'h25, 0, IRQ);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0000_0002, 0, 0,  0, 7'h25, 0, IRQ);
        add(1, 32'h3000_0080, 32'h0000_0101, 0, 1, 32'h0,         0, 0,  1, 7'h25, 0, IRQ);
        add(1, 32'h3000_0088, 32'h0000_0002, 1, 1, 32'h0,         0, 0,  0, 7'h25, 0, IRQ);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0000_0002, 0, 0,  0, 7'h25, 0, IRQ);
        add(1, 32'h3000_0088, 32'h0000_0002, 0, 1, 32'h0,         0, 0,  0, 7'h25, 0, 0);
        add(1, 32'h3000_0084, 32'h0,         0, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(1, 32'h3000_0080, 32'h0000_0001, 0, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(1, 32'h3100_0000, 32'h1234_5678, 0, 0, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(0, 32'h3000_0090, 32'h0,         0, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(1, 32'h3000_008C, 32'hFFFF_FFFF, 0, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(1, 32'h3000_0090, 32'h0,         1, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(0, 32'h3000_0088, 32'h0,         0, 1, 32'h0,         0, 0,  0, 7'h00, 0, 0);
        add(0, 32'h3000_0000, 32'h0,         0, 2, 32'hA5A5_0001, 0, 0,  0, 7'h00, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst ack",     {31'h0, wbs_ack_o}, 32'h0);
        chk("rst dat_o",   wbs_dat_o, 32'h0);
        chk("rst wb_we",   {31'h0, wb_we}, 32'h1);
        chk("rst wb_addr", {27'h0, wb_addr}, 32'h0);
        chk("rst datain",  datain_wb, 32'h0);
        chk("rst busy",    {31'h0, busy}, 32'h0);
        chk("rst datalen", {25'h0, datalen}, 32'h0);
        chk("rst mode",    {31'h0, mode}, 32'h0);
        chk("rst irq",     {31'h0, irq}, 32'h0);
        nRST = 1'b1;

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].done, lat, rd, we_low, waddr, wdata);
            $display("vec %0d: we=%0b adr=%h dat=%h done=%0b lat=%0d rd=%h busy=%0b len=%0d mode=%0b irq=%0b",
                     i, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].done, lat, rd, busy, datalen, mode, irq);
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            if (!vecs[i].we && vecs[i].lat != 0) chk($sformatf("v%0d rdata", i), rd, vecs[i].rd);
            chk($sformatf("v%0d wb_we_low_cycles", i), we_low, vecs[i].we_low);
            if (vecs[i].we_low == 1) begin
                chk($sformatf("v%0d wb_addr", i), {27'h0, waddr}, {27'h0, vecs[i].waddr});
                chk($sformatf("v%0d datain_wb", i), wdata, vecs[i].dat);
            end
            chk($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
            chk($sformatf("v%0d datalen", i), {25'h0, datalen}, {25'h0, vecs[i].len});
            chk($sformatf("v%0d mode", i), {31'h0, mode}, {31'h0, vecs[i].mode});
            chk($sformatf("v%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].irq});
        end

        // Mid-access reset: start an operation, begin a buffer read, then reset in RD_WAIT
        access(1, 32'h3000_0084, 32'h5, 0, lat, rd, we_low, waddr, wdata);
        access(1, 32'h3000_0080, 32'h3, 0, lat, rd, we_low, waddr, wdata);
        chk("pre-reset busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0000;
        @(posedge clk); #1;
        nRST = 1'b0;
        #1;
        $display("midreset: ack=%0b busy=%0b len=%0d mode=%0b", wbs_ack_o, busy, datalen, mode);
        chk("midrst ack",     {31'h0, wbs_ack_o}, 32'h0);
        chk("midrst dat_o",   wbs_dat_o, 32'h0);
        chk("midrst busy",    {31'h0, busy}, 32'h0);
        chk("midrst datalen", {25'h0, datalen}, 32'h0);
        chk("midrst mode",    {31'h0, mode}, 32'h0);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst ack c%0d", c), {31'h0, wbs_ack_o}, 32'h0);
        end
        chk("postrst wb_addr", {27'h0, wb_addr}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
